// File: rtl/clock_pkg.sv
// Shared types, field widths and BCD helpers for the clock time-entry logic.
package clock_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHour,
      StMin,
      StSec,
      StCommit
   } state_e;

   typedef enum logic [1:0] {
      FieldNone = 2'b00,
      FieldHour = 2'b01,
      FieldMin  = 2'b10,
      FieldSec  = 2'b11
   } field_e;

   localparam int unsigned HOUR_W   = 6;
   localparam int unsigned MINSEC_W = 7;

   localparam logic [HOUR_W-1:0]   HOUR_MAX   = 6'h23;
   localparam logic [MINSEC_W-1:0] MINSEC_MAX = 7'h59;

   // Hour callers zero-extend into the 7-bit form; the tens digit is bounded by max.
   function automatic logic bcd_valid(input logic [6:0] val, input logic [6:0] max);
      return (val[3:0] <= 4'd9) && (val <= max);
   endfunction

endpackage

// File: rtl/time_setter_dec_if.sv
// Button/time bundle between the synchronizers, the time setter and the clock core.
interface time_setter_dec_if;

   logic [19:0] time_cur;
   logic        btn_mode;
   logic        btn_inc;
   logic        btn_dec;
   logic        btn_cancel;
   logic [19:0] time_set;
   logic        time_ow;
   logic        editing;
   logic [1:0]  field;

   modport master (
      output time_cur, btn_mode, btn_inc, btn_dec, btn_cancel,
      input  time_set, time_ow, editing, field
   );

   modport slave (
      input  time_cur, btn_mode, btn_inc, btn_dec, btn_cancel,
      output time_set, time_ow, editing, field
   );

endinterface

// File: rtl/bcd_wrap_step.sv
// Combinational single-field BCD increment/decrement with wrap at 0 and MAX.
module bcd_wrap_step #(
   parameter int unsigned    W   = 7,
   parameter logic [W-1:0]   MAX = W'(8'h59)
) (
   input  logic [W-1:0] val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] next
);

   localparam logic [W-5:0] TensOne = (W-4)'(1);

   logic [3:0]   units;
   logic [W-5:0] tens;

   assign units = val[3:0];
   assign tens  = val[W-1:4];

   always_comb begin
      next = val;
      if (inc && !dec) begin
         if (val == MAX)          next = '0;
         else if (units == 4'd9) next = {tens + TensOne, 4'd0};
         else                     next = {tens, units + 4'd1};
      end else if (dec && !inc) begin
         if (val == '0)           next = MAX;
         else if (units == 4'd0) next = {tens - TensOne, 4'd9};
         else                     next = {tens, units - 4'd1};
      end
   end

endmodule

// File: rtl/time_setter_dec.sv
// Time-entry FSM: snapshot running time, step hour/min/sec with auto-repeat,
// then commit with a single-cycle overwrite strobe.
module time_setter_dec
   import clock_pkg::*;
#(
   parameter int unsigned REPEAT_DLY  = 50,
   parameter int unsigned REPEAT_RATE = 10
) (
   input  logic              clk,
   input  logic              rst,
   time_setter_dec_if.slave  bus
);

   localparam int unsigned MaxRpt = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int unsigned CntW   = $clog2(MaxRpt + 1);
   localparam logic [CntW-1:0] DlyCnt  = CntW'(REPEAT_DLY);
   localparam logic [CntW-1:0] RateCnt = CntW'(REPEAT_RATE);

   state_e          state_q;
   field_e          field_q;
   logic [19:0]     work_q;
   logic            ow_q;
   logic            editing_q;
   logic            mode_prev_q, inc_prev_q, dec_prev_q, cancel_prev_q;
   logic [CntW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic            rpt_phase_q, rpt_phase_d;

   logic mode_rise, inc_rise, dec_rise, cancel_rise;
   logic edit_st, hold_one, step;
   logic [CntW-1:0] cnt_inc;

   logic [HOUR_W-1:0]   hour_next;
   logic [MINSEC_W-1:0] min_next, sec_next;
   logic [19:0]         snap, work_step;

   assign mode_rise   = bus.btn_mode   & ~mode_prev_q;
   assign inc_rise    = bus.btn_inc    & ~inc_prev_q;
   assign dec_rise    = bus.btn_dec    & ~dec_prev_q;
   assign cancel_rise = bus.btn_cancel & ~cancel_prev_q;

   assign edit_st = (state_q == StHour) || (state_q == StMin) || (state_q == StSec);

   // Stepping only when one button is held and no higher-priority event this cycle.
   assign hold_one = edit_st && (bus.btn_inc ^ bus.btn_dec) && !cancel_rise && !mode_rise;
   assign cnt_inc  = rpt_cnt_q + CntW'(1);

   always_comb begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
      step        = 1'b0;
      if (hold_one) begin
         if (inc_rise || dec_rise) begin
            step = 1'b1;
         end else if (cnt_inc == (rpt_phase_q ? RateCnt : DlyCnt)) begin
            step        = 1'b1;
            rpt_phase_d = 1'b1;
         end else begin
            rpt_cnt_d   = cnt_inc;
            rpt_phase_d = rpt_phase_q;
         end
      end
   end

   bcd_wrap_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
      .val  (work_q[19:14]),
      .inc  (step && bus.btn_inc && (state_q == StHour)),
      .dec  (step && bus.btn_dec && (state_q == StHour)),
      .next (hour_next)
   );

   bcd_wrap_step #(.W(MINSEC_W), .MAX(MINSEC_MAX)) u_min (
      .val  (work_q[13:7]),
      .inc  (step && bus.btn_inc && (state_q == StMin)),
      .dec  (step && bus.btn_dec && (state_q == StMin)),
      .next (min_next)
   );

   bcd_wrap_step #(.W(MINSEC_W), .MAX(MINSEC_MAX)) u_sec (
      .val  (work_q[6:0]),
      .inc  (step && bus.btn_inc && (state_q == StSec)),
      .dec  (step && bus.btn_dec && (state_q == StSec)),
      .next (sec_next)
   );

   assign work_step = {hour_next, min_next, sec_next};

   always_comb begin
      snap = '0;
      if (bcd_valid({1'b0, bus.time_cur[19:14]}, {1'b0, HOUR_MAX})) begin
         snap[19:14] = bus.time_cur[19:14];
      end
      if (bcd_valid(bus.time_cur[13:7], MINSEC_MAX)) snap[13:7] = bus.time_cur[13:7];
      if (bcd_valid(bus.time_cur[6:0], MINSEC_MAX))  snap[6:0]  = bus.time_cur[6:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         field_q       <= FieldNone;
         work_q        <= '0;
         ow_q          <= 1'b0;
         editing_q     <= 1'b0;
         mode_prev_q   <= 1'b0;
         inc_prev_q    <= 1'b0;
         dec_prev_q    <= 1'b0;
         cancel_prev_q <= 1'b0;
         rpt_cnt_q     <= '0;
         rpt_phase_q   <= 1'b0;
      end else begin
         mode_prev_q   <= bus.btn_mode;
         inc_prev_q    <= bus.btn_inc;
         dec_prev_q    <= bus.btn_dec;
         cancel_prev_q <= bus.btn_cancel;
         rpt_cnt_q     <= rpt_cnt_d;
         rpt_phase_q   <= rpt_phase_d;
         ow_q          <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (mode_rise) begin
                  work_q    <= snap;
                  state_q   <= StHour;
                  field_q   <= FieldHour;
                  editing_q <= 1'b1;
               end
            end
            StHour, StMin, StSec: begin
               if (cancel_rise) begin
                  state_q   <= StIdle;
                  field_q   <= FieldNone;
                  editing_q <= 1'b0;
               end else if (mode_rise) begin
                  if (state_q == StHour) begin
                     state_q <= StMin;
                     field_q <= FieldMin;
                  end else if (state_q == StMin) begin
                     state_q <= StSec;
                     field_q <= FieldSec;
                  end else begin
                     state_q   <= StCommit;
                     field_q   <= FieldNone;
                     editing_q <= 1'b0;
                     ow_q      <= 1'b1;
                  end
               end else begin
                  work_q <= work_step;
               end
            end
            StCommit: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   assign bus.time_set = work_q;
   assign bus.time_ow  = ow_q;
   assign bus.editing  = editing_q;
   assign bus.field    = field_q;

endmodule

// File: tb/tb_time_setter_dec.sv
// Self-checking bench for time_setter_dec: direct checks plus a commit scoreboard.
module tb_time_setter_dec;

   localparam int BtnMode   = 0;
   localparam int BtnInc    = 1;
   localparam int BtnDec    = 2;
   localparam int BtnCancel = 3;

   logic clk;
   logic rst;
   time_setter_dec_if bus ();

   int n_checks = 0;
   int n_errors = 0;
   int ow_count = 0;
   logic [19:0] exp_q[$];

   time_setter_dec #(.REPEAT_DLY(50), .REPEAT_RATE(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] pk(input logic [5:0] h, input logic [6:0] m,
                                      input logic [6:0] s);
      return {h, m, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int which, input logic lvl);
      case (which)
         BtnMode:   bus.btn_mode   = lvl;
         BtnInc:    bus.btn_inc    = lvl;
         BtnDec:    bus.btn_dec    = lvl;
         default:   bus.btn_cancel = lvl;
      endcase
   endtask

   task automatic press(input int which);
      set_btn(which, 1'b1);
      tick();
      set_btn(which, 1'b0);
      tick();
   endtask

   // Each commit strobe consumes one expected value pushed before the final mode press.
   always @(negedge clk) begin
      if (bus.time_ow === 1'b1) begin
         ow_count++;
         if (exp_q.size() == 0) check("ow_unexpected", 32'(bus.time_ow), 32'd0);
         else                   check("ow_time_set", 32'(bus.time_set), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      rst            = 1'b0;
      bus.time_cur   = '0;
      bus.btn_mode   = 1'b0;
      bus.btn_inc    = 1'b0;
      bus.btn_dec    = 1'b0;
      bus.btn_cancel = 1'b0;
      repeat (2) tick();
      check("rst_time_set", 32'(bus.time_set), 32'd0);
      check("rst_ow", 32'(bus.time_ow), 32'd0);
      check("rst_editing", 32'(bus.editing), 32'd0);
      check("rst_field", 32'(bus.field), 32'd0);
      rst = 1'b1;
      tick();

      // Basic commit
      bus.time_cur = pk(6'h12, 7'h34, 7'h56);
      press(BtnMode);
      check("enter_editing", 32'(bus.editing), 32'd1);
      check("enter_field", 32'(bus.field), 32'd1);
      check("enter_snap", 32'(bus.time_set), 32'(pk(6'h12, 7'h34, 7'h56)));
      press(BtnInc);
      press(BtnInc);
      check("hour_inc2", 32'(bus.time_set), 32'(pk(6'h14, 7'h34, 7'h56)));
      press(BtnMode);
      check("field_min", 32'(bus.field), 32'd2);
      press(BtnDec);
      check("min_dec", 32'(bus.time_set), 32'(pk(6'h14, 7'h33, 7'h56)));
      press(BtnMode);
      check("field_sec", 32'(bus.field), 32'd3);
      exp_q.push_back(pk(6'h14, 7'h33, 7'h56));
      set_btn(BtnMode, 1'b1);
      tick();
      check("commit_ow", 32'(bus.time_ow), 32'd1);
      check("commit_editing", 32'(bus.editing), 32'd0);
      set_btn(BtnMode, 1'b0);
      tick();
      check("commit_ow_low", 32'(bus.time_ow), 32'd0);
      bus.time_cur = pk(6'h01, 7'h02, 7'h03);
      repeat (5) tick();
      check("hold_after_commit", 32'(bus.time_set), 32'(pk(6'h14, 7'h33, 7'h56)));
      check("one_pulse", 32'(ow_count), 32'd1);

      // Wrap behaviour, then cancel from SEC
      bus.time_cur = pk(6'h23, 7'h00, 7'h09);
      press(BtnMode);
      press(BtnInc);
      check("hour_wrap_up", 32'(bus.time_set), 32'(pk(6'h00, 7'h00, 7'h09)));
      press(BtnDec);
      check("hour_wrap_dn", 32'(bus.time_set), 32'(pk(6'h23, 7'h00, 7'h09)));
      press(BtnMode);
      press(BtnDec);
      check("min_wrap_dn", 32'(bus.time_set), 32'(pk(6'h23, 7'h59, 7'h09)));
      press(BtnMode);
      press(BtnInc);
      check("sec_carry", 32'(bus.time_set), 32'(pk(6'h23, 7'h59, 7'h10)));
      press(BtnCancel);
      check("cancel_editing", 32'(bus.editing), 32'd0);
      check("cancel_field", 32'(bus.field), 32'd0);
      check("cancel_keep", 32'(bus.time_set), 32'(pk(6'h23, 7'h59, 7'h10)));

      bus.time_cur = pk(6'h10, 7'h00, 7'h00);
      press(BtnMode);
      press(BtnDec);
      check("hour_borrow", 32'(bus.time_set), 32'(pk(6'h09, 7'h00, 7'h00)));
      press(BtnCancel);

      // Auto-repeat in MIN
      bus.time_cur = pk(6'h00, 7'h00, 7'h00);
      press(BtnMode);
      press(BtnMode);
      set_btn(BtnInc, 1'b1);
      repeat (50) tick();
      check("rpt_first", 32'(bus.time_set), 32'(pk(6'h00, 7'h01, 7'h00)));
      repeat (31) tick();
      set_btn(BtnInc, 1'b0);
      tick();
      check("rpt_total", 32'(bus.time_set), 32'(pk(6'h00, 7'h05, 7'h00)));
      press(BtnCancel);

      // Priority cases
      bus.time_cur = pk(6'h05, 7'h00, 7'h00);
      press(BtnMode);
      set_btn(BtnMode, 1'b1);
      set_btn(BtnCancel, 1'b1);
      tick();
      check("mode_cancel_editing", 32'(bus.editing), 32'd0);
      check("mode_cancel_field", 32'(bus.field), 32'd0);
      set_btn(BtnMode, 1'b0);
      set_btn(BtnCancel, 1'b0);
      tick();

      press(BtnMode);
      set_btn(BtnInc, 1'b1);
      set_btn(BtnDec, 1'b1);
      repeat (60) tick();
      check("inc_dec_both", 32'(bus.time_set), 32'(pk(6'h05, 7'h00, 7'h00)));
      set_btn(BtnInc, 1'b0);
      set_btn(BtnDec, 1'b0);
      tick();
      set_btn(BtnMode, 1'b1);
      set_btn(BtnInc, 1'b1);
      tick();
      check("mode_inc_field", 32'(bus.field), 32'd2);
      check("mode_inc_nostep", 32'(bus.time_set), 32'(pk(6'h05, 7'h00, 7'h00)));
      set_btn(BtnMode, 1'b0);
      set_btn(BtnInc, 1'b0);
      tick();
      press(BtnMode);
      press(BtnCancel);
      check("sec_cancel_editing", 32'(bus.editing), 32'd0);
      check("sec_cancel_no_ow", 32'(ow_count), 32'd1);

      // Snapshot normalization, then async reset while in MIN
      bus.time_cur = pk(6'h2F, 7'h7A, 7'h45);
      press(BtnMode);
      check("normalize", 32'(bus.time_set), 32'(pk(6'h00, 7'h00, 7'h45)));
      press(BtnMode);
      check("pre_rst_field", 32'(bus.field), 32'd2);
      rst = 1'b0;
      #2;
      check("arst_time_set", 32'(bus.time_set), 32'd0);
      check("arst_editing", 32'(bus.editing), 32'd0);
      check("arst_field", 32'(bus.field), 32'd0);
      check("arst_ow", 32'(bus.time_ow), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      bus.time_cur = pk(6'h07, 7'h08, 7'h09);
      press(BtnMode);
      check("restart_field", 32'(bus.field), 32'd1);
      check("restart_snap", 32'(bus.time_set), 32'(pk(6'h07, 7'h08, 7'h09)));
      press(BtnCancel);
      repeat (3) tick();

      check("ow_count_final", 32'(ow_count), 32'd1);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
